// File: rtl/av_sata_speed_ctrl.sv
// SATA speed negotiation: reconfigures the transceiver starting at MAX_GEN and
// falls back one generation at a time until the link holds stable or all fail.
module av_sata_speed_ctrl #(
    parameter int MAX_GEN       = 3,
    parameter int RECFG_TIMEOUT = 65536,
    parameter int LINK_TIMEOUT  = 1000000,
    parameter int LINK_STABLE   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       neg_start,
    input  logic       link_up,
    output logic       recfg_request,
    output logic [1:0] recfg_sata_gen,
    input  logic       recfg_ready,
    output logic       phy_restart,
    output logic       neg_done,
    output logic       neg_fail,
    output logic [1:0] neg_gen
);
    localparam int RT_W = $clog2(RECFG_TIMEOUT) + 1;
    localparam int LT_W = $clog2(LINK_TIMEOUT) + 1;
    localparam int ST_W = $clog2(LINK_STABLE) + 1;
    localparam logic [1:0]      GEN_TOP = 2'(MAX_GEN);
    localparam logic [RT_W-1:0] RT_LAST = RT_W'(RECFG_TIMEOUT - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LINK_TIMEOUT - 1);
    localparam logic [ST_W-1:0] ST_GOOD = ST_W'(LINK_STABLE);

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_RDY, S_REQ, S_WAIT_ACK, S_WAIT_DONE,
        S_RESTART, S_WAIT_LINK, S_DONE, S_FAIL
    } state_t;

    state_t          state, next_state;
    logic [1:0]      gen;
    logic [RT_W-1:0] rc_tmr;
    logic [LT_W-1:0] lk_tmr;
    logic [ST_W-1:0] stb_cnt, stb_nxt;
    logic            rc_expired, lk_expired, link_good;
    logic            req_nxt, restart_nxt, done_nxt, fail_nxt;
    logic [1:0]      sata_gen_nxt, neg_gen_nxt;

    function automatic logic [RT_W-1:0] rc_inc(input logic [RT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [LT_W-1:0] lk_inc(input logic [LT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ST_W-1:0] st_inc(input logic [ST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign stb_nxt    = link_up ? st_inc(stb_cnt) : '0;
    assign link_good  = (stb_nxt >= ST_GOOD);
    assign rc_expired = (rc_tmr >= RT_LAST);
    assign lk_expired = (lk_tmr >= LT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (neg_start) next_state = S_WAIT_RDY;
            S_WAIT_RDY:  if (rc_expired) next_state = S_FAIL;
                         else if (recfg_ready) next_state = S_REQ;
            S_REQ:       next_state = S_WAIT_ACK;
            S_WAIT_ACK:  if (rc_expired) next_state = S_FAIL;
                         else if (!recfg_ready) next_state = S_WAIT_DONE;
            S_WAIT_DONE: if (rc_expired) next_state = S_FAIL;
                         else if (recfg_ready) next_state = S_RESTART;
            S_RESTART:   next_state = S_WAIT_LINK;
            // A stable link on the final timer cycle still counts as success
            S_WAIT_LINK: if (link_good) next_state = S_DONE;
                         else if (lk_expired) next_state = (gen > 2'd1) ? S_WAIT_RDY : S_FAIL;
            S_DONE:      if (!link_up) next_state = S_WAIT_RDY;
            S_FAIL:      if (neg_start) next_state = S_WAIT_RDY;
            default:     next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it
    always_comb begin
        req_nxt      = (next_state == S_REQ);
        restart_nxt  = (next_state == S_RESTART);
        done_nxt     = (next_state == S_DONE);
        fail_nxt     = (next_state == S_FAIL);
        sata_gen_nxt = req_nxt ? gen : recfg_sata_gen;
        neg_gen_nxt  = (done_nxt && state != S_DONE) ? gen : neg_gen;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            recfg_request  <= 1'b0;
            recfg_sata_gen <= 2'd0;
            phy_restart    <= 1'b0;
            neg_done       <= 1'b0;
            neg_fail       <= 1'b0;
            neg_gen        <= 2'd0;
        end else begin
            recfg_request  <= req_nxt;
            recfg_sata_gen <= sata_gen_nxt;
            phy_restart    <= restart_nxt;
            neg_done       <= done_nxt;
            neg_fail       <= fail_nxt;
            neg_gen        <= neg_gen_nxt;
        end
    end

    // The handshake timer spans WAIT_RDY through WAIT_DONE of one attempt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gen     <= GEN_TOP;
            rc_tmr  <= '0;
            lk_tmr  <= '0;
            stb_cnt <= '0;
        end else begin
            if (next_state == S_WAIT_RDY && state != S_WAIT_RDY) begin
                rc_tmr <= '0;
                gen    <= (state == S_WAIT_LINK) ? gen - 2'd1 : GEN_TOP;
            end else if (state inside {S_WAIT_RDY, S_REQ, S_WAIT_ACK, S_WAIT_DONE}) begin
                rc_tmr <= rc_inc(rc_tmr);
            end
            if (state == S_RESTART) begin
                lk_tmr  <= '0;
                stb_cnt <= '0;
            end else if (state == S_WAIT_LINK) begin
                lk_tmr  <= lk_inc(lk_tmr);
                stb_cnt <= stb_nxt;
            end
        end
    end
endmodule

// File: doc/av_sata_speed_ctrl.md
AV_SATA_SPEED_CTRL -- requirements
Module: av_sata_speed_ctrl

Interface
REQ-001 Parameter MAX_GEN, default 3: first SATA generation tried (legal 1..3).
REQ-002 Parameter RECFG_TIMEOUT, default 65536: cycle limit for one reconfiguration handshake.
REQ-003 Parameter LINK_TIMEOUT, default 1000000: cycle limit for link establishment at one generation.
REQ-004 Parameter LINK_STABLE, default 16: consecutive link_up cycles required to declare the link good.
REQ-005 Port clk, input, 1: single clock, reconfig_clk domain; all logic is synchronous to it.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port neg_start, input, 1: single-cycle pulse that starts negotiation.
REQ-008 Port link_up, input, 1: link-layer indication that the PHY is ready and ALIGN is received, synchronous to clk.
REQ-009 Port recfg_request, output, 1: transceiver reconfiguration command pulse.
REQ-010 Port recfg_sata_gen, output, 2: target generation; 1=Gen1, 2=Gen2, 3=Gen3, 0 is never driven after the first request.
REQ-011 Port recfg_ready, input, 1: reconfiguration engine idle.
REQ-012 Port phy_restart, output, 1: single-cycle pulse that restarts OOB signalling.
REQ-013 Port neg_done, output, 1: link established.
REQ-014 Port neg_fail, output, 1: negotiation failed.
REQ-015 Port neg_gen, output, 2: generation in use, encoded as recfg_sata_gen; valid while neg_done=1.

Function
REQ-016 FSM states: IDLE, WAIT_RDY, REQ, WAIT_ACK, WAIT_DONE, RESTART, WAIT_LINK, DONE, FAIL.
REQ-017 IDLE: neg_start=1 loads gen:=MAX_GEN and moves to WAIT_RDY; otherwise the FSM holds.
REQ-018 WAIT_RDY: on recfg_ready=1 the FSM moves to REQ; the timer clears on entry; timer=RECFG_TIMEOUT-1 moves to FAIL.
REQ-019 REQ: recfg_request=1 and recfg_sata_gen=gen for exactly one cycle, then WAIT_ACK.
REQ-020 WAIT_ACK: recfg_ready=0 moves to WAIT_DONE; the timer continues from WAIT_RDY; expiry moves to FAIL.
REQ-021 WAIT_DONE: recfg_ready=1 moves to RESTART; expiry moves to FAIL.
REQ-022 RESTART: phy_restart=1 for exactly one cycle, then WAIT_LINK; the link timer and stable counter clear.
REQ-023 WAIT_LINK:
  - link_up=1 increments the stable counter; link_up=0 clears it.
  - Stable counter reaching LINK_STABLE moves to DONE with neg_gen:=gen.
  - Link timer reaching LINK_TIMEOUT-1 first, with gen>1: gen:=gen-1, move to WAIT_RDY.
  - Same expiry with gen=1: move to FAIL.
  - If the stable threshold and timer expiry occur in the same cycle, DONE wins.
REQ-024 DONE: neg_done=1. link_up=0 for one cycle clears neg_done next cycle, loads gen:=MAX_GEN and moves to WAIT_RDY (automatic renegotiation).
REQ-025 FAIL: neg_fail=1 held; neg_start=1 clears neg_fail, loads gen:=MAX_GEN and moves to WAIT_RDY.
REQ-026 neg_start is ignored in every state other than IDLE and FAIL.
REQ-027 All outputs are registered; recfg_request and phy_restart are never high simultaneously or for two consecutive cycles.
REQ-028 Counter widths are $clog2 of their limit plus 1; counters saturate and never wrap.
REQ-029 recfg_sata_gen holds its last value between requests.

Reset
REQ-030 reset=0 asynchronously forces IDLE, clears all counters, sets gen:=MAX_GEN, and drives recfg_request=0, recfg_sata_gen=0, phy_restart=0, neg_done=0, neg_fail=0, neg_gen=0.
REQ-031 Reset during any state, including mid-handshake, abandons the operation; no pulse is emitted on release.

Verification
REQ-032 Gen3 success: ready=1, neg_start.
  - Required: request is 1 cycle with gen=3.
  - Model drops ready for 10 cycles.
  - Required: phy_restart is 1 cycle.
  - link_up is held for 16 cycles; required: neg_done=1 and neg_gen=3.
REQ-033 Fallback: link_up never rises at gen 3 or 2, and rises at gen 1.
  - Required: requests with gen 3, 2, 1 in order.
  - Required: neg_done=1 and neg_gen=1.
  - LINK_TIMEOUT=100 in this bench.
REQ-034 Total failure: link_up=0 throughout. Required: three requests, then neg_fail=1. A later neg_start clears neg_fail and issues a gen-3 request.
REQ-035 Handshake timeout: recfg_ready stuck at 1 after the request. Required: neg_fail=1 at RECFG_TIMEOUT cycles after WAIT_RDY entry; phy_restart never pulses.
REQ-036 Glitchy link: link_up high 15 cycles, low 1, high 16. Required: neg_done only after the second run. In DONE, dropping link_up gives neg_done=0 and a new gen-3 request.
REQ-037 Reset asserted in WAIT_DONE. Required: all outputs 0 immediately. After release, idle until neg_start.
